// File: rtl/fpnew_fclass_pipe.sv
// ---------------------------------------------------------------------------
// fpnew_fclass_pipe
//   Pipelined FCLASS stage. It turns one operand plus the 8-bit classifier
//   info vector into the RISC-V 10-bit one-hot class mask. The mask and an
//   opaque tag then travel through NumPipeRegs register stages that use a
//   valid/ready handshake and can be flushed.
//
// Ports
//   clk_i, rst_i        clock (rising edge) and asynchronous active-high reset
//   in_valid_i/in_ready_o   input handshake
//   operand_i           raw operand; only the sign bit matters here
//   info_i              {normal, subnormal, zero, inf, nan, snan, qnan, boxed}
//   tag_i / tag_o       tag carried alongside the operation
//   flush_i             kills every in-flight operation
//   out_valid_o/out_ready_i output handshake
//   class_o             RISC-V class mask
//   busy_o              some stage holds a valid operation
// ---------------------------------------------------------------------------
module fpnew_fclass_pipe #(
    parameter logic [2:0]  FpFormat    = 3'd0,
    parameter int unsigned NumPipeRegs = 1,
    parameter int unsigned TagWidth    = 4,
    // Format codes: 0 FP32, 1 FP64, 2 FP16, 3 FP8 (1+5+2), 4 FP16ALT (1+8+7)
    localparam int unsigned WIDTH = (FpFormat == 3'd1) ? 64 :
                                    (FpFormat == 3'd2) ? 16 :
                                    (FpFormat == 3'd3) ? 8  :
                                    (FpFormat == 3'd4) ? 16 : 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [WIDTH-1:0]    operand_i,
    input  logic [7:0]          info_i,
    input  logic [TagWidth-1:0] tag_i,
    input  logic                flush_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [9:0]          class_o,
    output logic [TagWidth-1:0] tag_o,
    output logic                busy_o
);

    logic       sign;
    logic [9:0] mask_in;

    // Only the sign bit of the operand is relevant; the rest is classified upstream.
    logic unused_operand_bits;
    assign unused_operand_bits = ^operand_i[WIDTH-2:0];

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sign    = operand_i[WIDTH-1];
        // Quiet NaN doubles as the safe answer for unboxed or malformed info.
        mask_in = 10'h200;
        if (info_i[0] && ($countones(info_i[7:3]) == 1)) begin
            if (info_i[7])      mask_in = sign ? 10'h002 : 10'h040;
            else if (info_i[6]) mask_in = sign ? 10'h004 : 10'h020;
            else if (info_i[5]) mask_in = sign ? 10'h008 : 10'h010;
            else if (info_i[4]) mask_in = sign ? 10'h001 : 10'h080;
            // NaN: sign ignored; only an unambiguous signalling NaN leaves the default.
            else if (info_i[2] && !info_i[1]) mask_in = 10'h100;
        end
    end

    if (NumPipeRegs == 0) begin : gen_comb
        // Pure pass-through: no state, flush is meaningless.
        logic unused_ctrl;
        assign unused_ctrl = clk_i ^ rst_i ^ flush_i;

        assign out_valid_o = in_valid_i;
        assign in_ready_o  = out_ready_i;
        assign class_o     = mask_in;
        assign tag_o       = tag_i;
        assign busy_o      = 1'b0;
    end else begin : gen_pipe
        logic [NumPipeRegs-1:0] v_q, v_d, load;
        logic [NumPipeRegs:0]   rdy;
        logic [9:0]             mask_q [NumPipeRegs];
        logic [TagWidth-1:0]    tag_q  [NumPipeRegs];
        logic [9:0]             mask_s [NumPipeRegs];
        logic [TagWidth-1:0]    tag_s  [NumPipeRegs];

        // Stage k is ready unless it and every stage after it are full while the
        // output is stalled. Accumulating "all full" from the tail keeps the
        // chain free of a self-referencing vector.
        always_comb begin : ready_chain
            logic all_full;
            all_full         = 1'b1;
            rdy              = '0;
            rdy[NumPipeRegs] = out_ready_i;
            for (int k = int'(NumPipeRegs) - 1; k >= 0; k--) begin
                all_full = all_full & v_q[k];
                rdy[k]   = out_ready_i | ~all_full;
            end
        end

        always_comb begin
            load      = '0;
            v_d       = '0;
            mask_s[0] = mask_in;
            tag_s[0]  = tag_i;
            // A flush cycle never captures the incoming operation.
            load[0]   = in_valid_i & rdy[0] & ~flush_i;
            for (int k = 1; k < int'(NumPipeRegs); k++) begin
                mask_s[k] = mask_q[k-1];
                tag_s[k]  = tag_q[k-1];
                load[k]   = v_q[k-1] & rdy[k];
            end
            // Valid survives if refilled, or if its content cannot move on.
            for (int k = 0; k < int'(NumPipeRegs); k++) begin
                v_d[k] = ~flush_i & (load[k] | (v_q[k] & ~rdy[k+1]));
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples the pre-edge value of its neighbour.
        // NOTE: the data registers are reset as well, because class_o/tag_o
        // must read 0 straight out of reset.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                v_q <= '0;
                for (int k = 0; k < int'(NumPipeRegs); k++) begin
                    mask_q[k] <= '0;
                    tag_q[k]  <= '0;
                end
            end else begin
                v_q <= v_d;
                for (int k = 0; k < int'(NumPipeRegs); k++) begin
                    if (load[k]) begin
                        mask_q[k] <= mask_s[k];
                        tag_q[k]  <= tag_s[k];
                    end
                end
            end
        end

        assign in_ready_o  = rdy[0];
        assign out_valid_o = v_q[NumPipeRegs-1];
        assign class_o     = mask_q[NumPipeRegs-1];
        assign tag_o       = tag_q[NumPipeRegs-1];
        assign busy_o      = |v_q;
    end

endmodule

// File: tb/tb_fpnew_fclass_pipe.sv
// ---------------------------------------------------------------------------
// tb_fpnew_fclass_pipe
//   Exercises three instances of fpnew_fclass_pipe (FP32): NumPipeRegs = 0, 1
//   and 3. Operand, info and tag are shared; each instance has its own
//   handshake and flush controls. Expected masks come from a class-level
//   reference function; pipeline behaviour is modelled as an in-order FIFO of
//   accepted operations.
// ---------------------------------------------------------------------------
module tb_fpnew_fclass_pipe;

    typedef struct packed {
        logic [9:0] m;
        logic [3:0] t;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] operand = '0;
    logic [7:0]  info    = '0;
    logic [3:0]  tag     = '0;

    logic       in_valid0 = 0, out_ready0 = 0, flush0 = 0;
    logic       in_valid1 = 0, out_ready1 = 0, flush1 = 0;
    logic       in_valid3 = 0, out_ready3 = 0, flush3 = 0;
    logic       in_ready0, out_valid0, busy0;
    logic       in_ready1, out_valid1, busy1;
    logic       in_ready3, out_valid3, busy3;
    logic [9:0] class0, class1, class3;
    logic [3:0] tag_o0, tag_o1, tag_o3;

    int n_assert = 0;
    int n_fail   = 0;

    fpnew_fclass_pipe #(.FpFormat(3'd0), .NumPipeRegs(0), .TagWidth(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .operand_i(operand), .info_i(info), .tag_i(tag), .flush_i(flush0),
        .out_valid_o(out_valid0), .out_ready_i(out_ready0), .class_o(class0),
        .tag_o(tag_o0), .busy_o(busy0));

    fpnew_fclass_pipe #(.FpFormat(3'd0), .NumPipeRegs(1), .TagWidth(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .operand_i(operand), .info_i(info), .tag_i(tag), .flush_i(flush1),
        .out_valid_o(out_valid1), .out_ready_i(out_ready1), .class_o(class1),
        .tag_o(tag_o1), .busy_o(busy1));

    fpnew_fclass_pipe #(.FpFormat(3'd0), .NumPipeRegs(3), .TagWidth(4)) dut3 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid3), .in_ready_o(in_ready3),
        .operand_i(operand), .info_i(info), .tag_i(tag), .flush_i(flush3),
        .out_valid_o(out_valid3), .out_ready_i(out_ready3), .class_o(class3),
        .tag_o(tag_o3), .busy_o(busy3));

    // Reference: name the class, then place it in the RISC-V mask.
    function automatic logic [9:0] ref_class(input logic s, input logic [7:0] inf);
        int n_classes;
        n_classes = int'(inf[7]) + int'(inf[6]) + int'(inf[5]) + int'(inf[4]) + int'(inf[3]);
        if (!inf[0] || n_classes != 1) return 10'h200;
        if (inf[4]) return s ? (10'd1 << 0) : (10'd1 << 7);
        if (inf[7]) return s ? (10'd1 << 1) : (10'd1 << 6);
        if (inf[6]) return s ? (10'd1 << 2) : (10'd1 << 5);
        if (inf[5]) return s ? (10'd1 << 3) : (10'd1 << 4);
        if (inf[2] && !inf[1]) return 10'd1 << 8;
        return 10'd1 << 9;
    endfunction

    task automatic rand_inputs();
        logic [4:0] g;
        operand = $urandom();
        tag     = 4'($urandom());
        case ($urandom_range(0, 7))
            0: info = 8'h81;
            1: info = 8'h41;
            2: info = 8'h21;
            3: info = 8'h11;
            4: info = 8'h0D;
            5: info = 8'h0B;
            6: info = 8'h0A;
            default: begin
                g = 5'($urandom()) | 5'b00011;
                if ($urandom_range(0, 3) == 0) g = 5'b0;
                info = {g, 3'b001};
            end
        endcase
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_assert++; if ({out_valid1, class1, tag_o1, busy1} !== 16'h0) begin n_fail++; $display("FAIL reset_n1: got v=%b c=%h t=%h b=%b, expected all 0", out_valid1, class1, tag_o1, busy1); end
        n_assert++; if ({out_valid3, class3, tag_o3, busy3} !== 16'h0) begin n_fail++; $display("FAIL reset_n3: got v=%b c=%h t=%h b=%b, expected all 0", out_valid3, class3, tag_o3, busy3); end
        rst = 1'b0;
        @(negedge clk);
        n_assert++; if ({in_ready1, in_ready3} !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b, expected 11", {in_ready1, in_ready3}); end
        n_assert++; if ({out_valid1, out_valid3, busy1, busy3, busy0} !== 5'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 00000", {out_valid1, out_valid3, busy1, busy3, busy0}); end
    endtask

    task automatic test_fclass_n1();
        logic [31:0] ops  [5] = '{32'hFF800000, 32'h00000000, 32'h3F800000, 32'h7F800001, 32'h80000001};
        logic [7:0]  infs [5] = '{8'h11, 8'h21, 8'h0B, 8'h0D, 8'h41};
        logic [9:0]  exps [5] = '{10'h001, 10'h010, 10'h200, 10'h100, 10'h004};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            operand = ops[i]; info = infs[i]; tag = 4'(i + 1);
            in_valid1 = 1'b1; out_ready1 = 1'b1;
            @(negedge clk);
            n_assert++; if ({out_valid1, in_ready1} !== 2'b01) begin n_fail++; $display("FAIL n1_idle[%0d]: got v=%b r=%b, expected v=0 r=1", i, out_valid1, in_ready1); end
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            @(negedge clk);
            n_assert++; if ({out_valid1, class1, tag_o1} !== {1'b1, exps[i], 4'(i + 1)}) begin n_fail++; $display("FAIL n1_class[%0d]: got v=%b c=%h t=%h, expected v=1 c=%h t=%h", i, out_valid1, class1, tag_o1, exps[i], 4'(i + 1)); end
        end
        @(negedge clk);
        n_assert++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL n1_drain: got v=%b, expected 0", out_valid1); end
    endtask

    task automatic test_backpressure_n3();
        op_t        q[$];
        op_t        e;
        int         next_tag = 1;
        int         got = 0;
        logic [9:0] hc = '0;
        logic [3:0] ht = '0;
        logic       exp_rdy;
        @(posedge clk); #1;
        out_ready3 = 1'b0;
        rand_inputs(); tag = 4'd1; in_valid3 = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            exp_rdy = (cyc < 3);
            n_assert++; if (in_ready3 !== exp_rdy) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b, expected %b", cyc, in_ready3, exp_rdy); end
            if (cyc == 3) begin
                n_assert++; if ({out_valid3, tag_o3} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL bp_head: got v=%b t=%h, expected v=1 t=1", out_valid3, tag_o3); end
                hc = class3; ht = tag_o3;
            end
            if (cyc == 4) begin
                n_assert++; if ({out_valid3, class3, tag_o3} !== {1'b1, hc, ht}) begin n_fail++; $display("FAIL bp_stable: got v=%b c=%h t=%h, expected v=1 c=%h t=%h", out_valid3, class3, tag_o3, hc, ht); end
            end
            if (in_valid3 && in_ready3) begin q.push_back('{ref_class(operand[31], info), tag}); next_tag++; end
            @(posedge clk); #1;
            if (next_tag <= 4 && tag != 4'(next_tag)) begin rand_inputs(); tag = 4'(next_tag); end
            in_valid3 = (next_tag <= 4);
        end
        out_ready3 = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            @(negedge clk);
            if (out_valid3 && out_ready3) begin
                n_assert++;
                if (q.size() == 0) begin n_fail++; $display("FAIL bp_spurious: got t=%h, expected no output", tag_o3); end
                else begin
                    e = q.pop_front();
                    if ({class3, tag_o3} !== {e.m, 4'(got + 1)}) begin n_fail++; $display("FAIL bp_order[%0d]: got c=%h t=%h, expected c=%h t=%h", got, class3, tag_o3, e.m, 4'(got + 1)); end
                end
                got++;
            end
            if (in_valid3 && in_ready3) begin q.push_back('{ref_class(operand[31], info), tag}); next_tag++; end
            @(posedge clk); #1;
            if (next_tag <= 4 && tag != 4'(next_tag)) begin rand_inputs(); tag = 4'(next_tag); end
            in_valid3 = (next_tag <= 4);
        end
        n_assert++; if (got !== 4) begin n_fail++; $display("FAIL bp_count: got %0d outputs, expected 4", got); end
        @(negedge clk);
        n_assert++; if ({out_valid3, busy3} !== 2'b00) begin n_fail++; $display("FAIL bp_dup: got v=%b b=%b, expected 00", out_valid3, busy3); end
    endtask

    task automatic test_flush_n3();
        @(posedge clk); #1;
        out_ready3 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_inputs(); tag = 4'(5 + i); in_valid3 = 1'b1;
            @(posedge clk); #1;
        end
        rand_inputs(); tag = 4'd7; flush3 = 1'b1;
        @(negedge clk);
        n_assert++; if ({in_ready3, busy3} !== 2'b11) begin n_fail++; $display("FAIL flush_ready: got r=%b b=%b, expected 11", in_ready3, busy3); end
        @(posedge clk); #1;
        flush3 = 1'b0; in_valid3 = 1'b0;
        @(negedge clk);
        n_assert++; if ({out_valid3, busy3} !== 2'b00) begin n_fail++; $display("FAIL flush_clear: got v=%b b=%b, expected 00", out_valid3, busy3); end
        out_ready3 = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            n_assert++; if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL flush_leak[%0d]: got v=%b t=%h, expected no output", cyc, out_valid3, tag_o3); end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        out_ready3 = 1'b0; out_ready1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs(); in_valid3 = 1'b1; in_valid1 = (i == 0);
            @(posedge clk); #1;
        end
        in_valid3 = 1'b0; in_valid1 = 1'b0;
        @(negedge clk);
        n_assert++; if ({out_valid3, busy3, out_valid1} !== 3'b111) begin n_fail++; $display("FAIL pre_rst: got %b, expected 111", {out_valid3, busy3, out_valid1}); end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_assert++; if ({out_valid3, class3, tag_o3, busy3} !== 16'h0) begin n_fail++; $display("FAIL rst_async_n3: got v=%b c=%h t=%h b=%b, expected all 0", out_valid3, class3, tag_o3, busy3); end
        n_assert++; if ({out_valid1, class1, tag_o1, busy1} !== 16'h0) begin n_fail++; $display("FAIL rst_async_n1: got v=%b c=%h t=%h b=%b, expected all 0", out_valid1, class1, tag_o1, busy1); end
        #2;
        rst = 1'b0;
        @(negedge clk);
        n_assert++; if ({in_ready3, in_ready1, out_valid3, out_valid1} !== 4'b1100) begin n_fail++; $display("FAIL rst_release: got %b, expected 1100", {in_ready3, in_ready1, out_valid3, out_valid1}); end
        out_ready3 = 1'b1; out_ready1 = 1'b1;
    endtask

    task automatic test_comb_n0();
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk); #1;
            rand_inputs();
            in_valid0  = (cyc < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready0 = 1'(cyc % 2);
            flush0     = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_assert++; if ({out_valid0, in_ready0, busy0} !== {in_valid0, out_ready0, 1'b0}) begin n_fail++; $display("FAIL n0_hs[%0d]: got v=%b r=%b b=%b, expected v=%b r=%b b=0", cyc, out_valid0, in_ready0, busy0, in_valid0, out_ready0); end
            n_assert++; if ({class0, tag_o0} !== {ref_class(operand[31], info), tag}) begin n_fail++; $display("FAIL n0_data[%0d]: got c=%h t=%h, expected c=%h t=%h", cyc, class0, tag_o0, ref_class(operand[31], info), tag); end
        end
        in_valid0 = 1'b0; flush0 = 1'b0;
    endtask

    task automatic test_random();
        op_t        q1[$], q3[$];
        op_t        e;
        logic       hold1 = 0, hold3 = 0;
        logic [9:0] hc1 = '0, hc3 = '0;
        logic [3:0] ht1 = '0, ht3 = '0;
        logic       exp_rdy;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            rand_inputs();
            in_valid1  = ($urandom_range(0, 3) != 0);
            in_valid3  = ($urandom_range(0, 3) != 0);
            out_ready1 = ($urandom_range(0, 2) != 0);
            out_ready3 = ($urandom_range(0, 2) != 0);
            flush1     = ($urandom_range(0, 29) == 0);
            flush3     = ($urandom_range(0, 24) == 0);
            @(negedge clk);
            // NumPipeRegs = 1
            if (hold1) begin
                n_assert++; if ({out_valid1, class1, tag_o1} !== {1'b1, hc1, ht1}) begin n_fail++; $display("FAIL rnd_stable1[%0d]: got v=%b c=%h t=%h, expected v=1 c=%h t=%h", cyc, out_valid1, class1, tag_o1, hc1, ht1); end
            end
            exp_rdy = out_ready1 || (q1.size() < 1);
            n_assert++; if (in_ready1 !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready1[%0d]: got %b, expected %b", cyc, in_ready1, exp_rdy); end
            if (out_valid1 && out_ready1) begin
                n_assert++;
                if (q1.size() == 0) begin n_fail++; $display("FAIL rnd_spurious1[%0d]: got t=%h, expected no output", cyc, tag_o1); end
                else begin
                    e = q1.pop_front();
                    if ({class1, tag_o1} !== {e.m, e.t}) begin n_fail++; $display("FAIL rnd_data1[%0d]: got c=%h t=%h, expected c=%h t=%h", cyc, class1, tag_o1, e.m, e.t); end
                end
            end
            if (flush1) q1.delete();
            else if (in_valid1 && in_ready1) q1.push_back('{ref_class(operand[31], info), tag});
            hold1 = out_valid1 && !out_ready1 && !flush1; hc1 = class1; ht1 = tag_o1;
            // NumPipeRegs = 3
            if (hold3) begin
                n_assert++; if ({out_valid3, class3, tag_o3} !== {1'b1, hc3, ht3}) begin n_fail++; $display("FAIL rnd_stable3[%0d]: got v=%b c=%h t=%h, expected v=1 c=%h t=%h", cyc, out_valid3, class3, tag_o3, hc3, ht3); end
            end
            exp_rdy = out_ready3 || (q3.size() < 3);
            n_assert++; if (in_ready3 !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready3[%0d]: got %b, expected %b", cyc, in_ready3, exp_rdy); end
            if (out_valid3 && out_ready3) begin
                n_assert++;
                if (q3.size() == 0) begin n_fail++; $display("FAIL rnd_spurious3[%0d]: got t=%h, expected no output", cyc, tag_o3); end
                else begin
                    e = q3.pop_front();
                    if ({class3, tag_o3} !== {e.m, e.t}) begin n_fail++; $display("FAIL rnd_data3[%0d]: got c=%h t=%h, expected c=%h t=%h", cyc, class3, tag_o3, e.m, e.t); end
                end
            end
            if (flush3) q3.delete();
            else if (in_valid3 && in_ready3) q3.push_back('{ref_class(operand[31], info), tag});
            hold3 = out_valid3 && !out_ready3 && !flush3; hc3 = class3; ht3 = tag_o3;
        end
        @(posedge clk); #1;
        in_valid1 = 0; in_valid3 = 0; flush1 = 0; flush3 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fclass_n1();
        test_backpressure_n3();
        test_flush_n3();
        test_async_reset();
        test_comb_n0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
